// File: rtl/cfu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cfu_ctrl_pkg
// Shared definitions for the CFU controller slice: lane geometry defaults,
// custom-instruction opcodes (funct3), controller state encoding and the
// response-source decode helper.
// Build option: CFU_CTRL_PROD_STAGE_EN (used by cfu_ctrl, not here).
// -----------------------------------------------------------------------------
package cfu_ctrl_pkg;

    localparam int CFU_LANES  = 4;
    localparam int CFU_LANE_W = 8;
    localparam int CFU_DATA_W = 32;

    localparam logic [2:0] OP_WR_OFF  = 3'd0;
    localparam logic [2:0] OP_CLR_ACC = 3'd1;
    localparam logic [2:0] OP_MAC     = 3'd2;
    localparam logic [2:0] OP_RD_ACC  = 3'd3;
    localparam logic [2:0] OP_RD_OFF  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_OFF  = 2'd1,
        SRC_ACC  = 2'd2
    } rsp_src_e;

    // Which register-block value an opcode returns once its flag has landed.
    function automatic rsp_src_e rsp_src(input logic [2:0] op);
        rsp_src_e src;
        case (op)
            OP_WR_OFF, OP_RD_OFF: src = SRC_OFF;
            OP_MAC, OP_RD_ACC:    src = SRC_ACC;
            default:              src = SRC_ZERO;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/cfu_ctrl_if.sv
// -----------------------------------------------------------------------------
// cfu_ctrl_if
// CPU custom-function-unit command/response bus.
//   cmd_valid/cmd_ready         command handshake
//   cmd_function_id[9:0]        {funct7, funct3}
//   cmd_inputs_0/1[31:0]        rs1/rs2 operands
//   rsp_valid/rsp_ready         response handshake
//   rsp_outputs_0[31:0]         response data
// master = CPU side, slave = cfu_ctrl side.
// -----------------------------------------------------------------------------
interface cfu_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_function_id;
    logic [31:0] cmd_inputs_0;
    logic [31:0] cmd_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_outputs_0;

    modport master (
        output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_outputs_0
    );
endinterface

// File: rtl/cfu_mac_lanes.sv
// -----------------------------------------------------------------------------
// cfu_mac_lanes
// Combinational int8 MAC datapath, split in two halves so the top can put a
// register between them:
//   op_a, op_b, offset -> prod[i] = (sext(a_i) + offset) * sext(b_i)
//   prod_in            -> sum     = sum of prod_in lanes
// All arithmetic is 32-bit two's complement, wrapping, no saturation.
// Lane i occupies bits [LANE_W*i +: LANE_W]; LANES*LANE_W must be 32.
// -----------------------------------------------------------------------------
module cfu_mac_lanes
    import cfu_ctrl_pkg::*;
#(
    parameter int LANES  = CFU_LANES,
    parameter int LANE_W = CFU_LANE_W
) (
    input  logic [31:0]             op_a,
    input  logic [31:0]             op_b,
    input  logic [31:0]             offset,
    output logic [LANES-1:0][31:0]  prod,
    input  logic [LANES-1:0][31:0]  prod_in,
    output logic [31:0]             sum
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [LANE_W-1:0] a_lane_s;
        logic signed [LANE_W-1:0] b_lane_s;
        logic signed [31:0]       a_ext_s;
        logic signed [31:0]       b_ext_s;

        assign a_lane_s = op_a[i*LANE_W +: LANE_W];
        assign b_lane_s = op_b[i*LANE_W +: LANE_W];
        // Size cast of a signed lane sign-extends it to 32 bits.
        assign a_ext_s  = 32'(a_lane_s);
        assign b_ext_s  = 32'(b_lane_s);
        assign prod[i]  = (a_ext_s + $signed(offset)) * b_ext_s;
    end

    // Sum tree over the (possibly registered) lane products.
    always_comb begin
        sum = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + prod_in[i];
        end
    end

endmodule

// File: rtl/cfu_ctrl.sv
// -----------------------------------------------------------------------------
// cfu_ctrl
// CFU-bus responder driving the offset/accumulator register block.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfu (slave)           CPU command/response bus (cfu_ctrl_if)
//   flag_write_offset     1-cycle pulse: register block loads value_out to offset
//   flag_add_acc          1-cycle pulse: register block adds value_out to acc
//   flag_clear_acc        1-cycle pulse: register block clears acc
//   value_out[31:0]       operand for the register block
//   offset_in, acc_in     current register block contents
// Build option: define CFU_CTRL_PROD_STAGE_EN to register the MAC lane
// products in an extra PROD state (MAC latency 3 instead of 2).
// Sequencing: IDLE -> [PROD] -> EXEC (flag) -> RSP (hold until accepted).
// -----------------------------------------------------------------------------
module cfu_ctrl
    import cfu_ctrl_pkg::*;
#(
    parameter int LANES  = CFU_LANES,
    parameter int LANE_W = CFU_LANE_W
) (
    input  logic        clk,
    input  logic        reset,
    cfu_ctrl_if.slave   cfu,
    output logic        flag_write_offset,
    output logic        flag_add_acc,
    output logic        flag_clear_acc,
    output logic [31:0] value_out,
    input  logic [31:0] offset_in,
    input  logic [31:0] acc_in
);

    state_e                 state_r;
    state_e                 next_state_s;
    logic [2:0]             op_r;
    logic [31:0]            in0_r;
    logic [31:0]            in1_r;
    logic [2:0]             funct3_s;
    logic [LANES-1:0][31:0] prod_s;
    logic [LANES-1:0][31:0] prod_sum_s;
    logic [31:0]            sum_s;

    logic                   cmd_ready_s;
    logic                   rsp_valid_s;
    logic                   flag_wr_s;
    logic                   flag_add_s;
    logic                   flag_clr_s;
    logic [31:0]            value_s;
    logic [31:0]            rsp_data_s;

    // funct7 is deliberately ignored.
    assign funct3_s = cfu.cmd_function_id[2:0];

    cfu_mac_lanes #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_mac_lanes (
        .op_a    (in0_r),
        .op_b    (in1_r),
        .offset  (offset_in),
        .prod    (prod_s),
        .prod_in (prod_sum_s),
        .sum     (sum_s)
    );

`ifdef CFU_CTRL_PROD_STAGE_EN
    localparam bit PROD_EN = 1'b1;
    logic [LANES-1:0][31:0] prod_r;

    // Product pipeline register, captured while in PROD.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r <= '0;
        end else if (state_r == ST_PROD) begin
            prod_r <= prod_s;
        end
    end

    assign prod_sum_s = prod_r;
`else
    localparam bit PROD_EN = 1'b0;
    assign prod_sum_s = prod_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Command capture on the accept handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r  <= 3'd0;
            in0_r <= 32'd0;
            in1_r <= 32'd0;
        end else if (state_r == ST_IDLE && cfu.cmd_valid) begin
            op_r  <= funct3_s;
            in0_r <= cfu.cmd_inputs_0;
            in1_r <= cfu.cmd_inputs_1;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        next_state_s = state_r;
        cmd_ready_s  = 1'b0;
        rsp_valid_s  = 1'b0;
        flag_wr_s    = 1'b0;
        flag_add_s   = 1'b0;
        flag_clr_s   = 1'b0;
        value_s      = 32'd0;
        rsp_data_s   = 32'd0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cfu.cmd_valid) begin
                    if (PROD_EN && funct3_s == OP_MAC) begin
                        next_state_s = ST_PROD;
                    end else begin
                        next_state_s = ST_EXEC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PROD: begin
                next_state_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_r)
                    OP_WR_OFF: begin
                        flag_wr_s = 1'b1;
                        value_s   = in0_r;
                    end
                    OP_CLR_ACC: begin
                        flag_clr_s = 1'b1;
                    end
                    OP_MAC: begin
                        flag_add_s = 1'b1;
                        value_s    = sum_s;
                    end
                    default: begin
                        value_s = 32'd0;
                    end
                endcase
                next_state_s = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid_s = 1'b1;
                // Read live: the flag from EXEC has already been applied, and
                // nothing fires while here, so the value holds under backpressure.
                case (rsp_src(op_r))
                    SRC_OFF: rsp_data_s = offset_in;
                    SRC_ACC: rsp_data_s = acc_in;
                    default: rsp_data_s = 32'd0;
                endcase
                if (cfu.rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RSP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Reset masks every output at once so an aborted command emits nothing.
    assign cfu.cmd_ready     = cmd_ready_s & ~reset;
    assign cfu.rsp_valid     = rsp_valid_s & ~reset;
    assign cfu.rsp_outputs_0 = reset ? 32'd0 : rsp_data_s;
    assign flag_write_offset = flag_wr_s & ~reset;
    assign flag_add_acc      = flag_add_s & ~reset;
    assign flag_clear_acc    = flag_clr_s & ~reset;
    assign value_out         = reset ? 32'd0 : value_s;

endmodule

// File: tb/tb_cfu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cfu_ctrl
// Scoreboard bench for cfu_ctrl. A small register block sits on the flag
// bus; directed commands push expected flags and responses into queues that a
// negedge monitor pops as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_cfu_ctrl;
    import cfu_ctrl_pkg::*;

`ifdef CFU_CTRL_PROD_STAGE_EN
    localparam int MAC_LAT = 3;
`else
    localparam int MAC_LAT = 2;
`endif
    localparam int K_WR  = 1;
    localparam int K_CLR = 2;
    localparam int K_ADD = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } flg_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } rsp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        flag_write_offset;
    logic        flag_add_acc;
    logic        flag_clear_acc;
    logic [31:0] value_out;
    logic [31:0] off_m = 32'd0;
    logic [31:0] acc_m = 32'd0;

    flg_t flg_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    int   hs_cyc  = -10;

    // monitor-private state
    int          nflag;
    int          kind;
    bit          rsp_seen = 1'b0;
    logic [31:0] held;
    flg_t        fe;
    rsp_t        re;

    always #5 clk = ~clk;

    cfu_ctrl_if bus ();

    cfu_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cfu               (bus),
        .flag_write_offset (flag_write_offset),
        .flag_add_acc      (flag_add_acc),
        .flag_clear_acc    (flag_clear_acc),
        .value_out         (value_out),
        .offset_in         (off_m),
        .acc_in            (acc_m)
    );

    // register block model
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flag_write_offset) off_m <= value_out;
        if (flag_clear_acc) acc_m <= 32'd0;
        else if (flag_add_acc) acc_m <= acc_m + value_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            nflag = int'(flag_write_offset) + int'(flag_add_acc) + int'(flag_clear_acc);
            if (nflag > 1) begin
                checks++; errors++;
                $display("FAIL flag_onehot: %0d flags high, required at most 1", nflag);
            end else if (nflag == 1) begin
                checks++;
                kind = flag_write_offset ? K_WR : (flag_clear_acc ? K_CLR : K_ADD);
                if (flg_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flag: got kind %0d, required none", kind);
                end else begin
                    fe = flg_q.pop_front();
                    if (fe.kind != kind || (kind != K_CLR && value_out !== fe.val)) begin
                        errors++;
                        $display("FAIL flag: got kind %0d value 0x%08h, required kind %0d value 0x%08h",
                                 kind, value_out, fe.kind, fe.val);
                    end
                end
            end
            if (reset) begin
                rsp_seen = 1'b0;
                checks++;
                if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: got rsp_valid %b cmd_ready %b, required 0 0",
                             bus.rsp_valid, bus.cmd_ready);
                end
            end else if (bus.rsp_valid) begin
                checks++;
                if (!rsp_seen) begin
                    if (rsp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got data 0x%08h, required no response", bus.rsp_outputs_0);
                    end else if (cyc - acc_cyc != rsp_q[0].lat) begin
                        errors++;
                        $display("FAIL latency: got %0d, required %0d", cyc - acc_cyc, rsp_q[0].lat);
                    end
                    rsp_seen = 1'b1;
                    held = bus.rsp_outputs_0;
                end else if (bus.rsp_outputs_0 !== held || bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_hold: got data 0x%08h cmd_ready %b, required 0x%08h 0",
                             bus.rsp_outputs_0, bus.cmd_ready, held);
                end
                if (bus.rsp_ready) begin
                    rsp_seen = 1'b0;
                    hs_cyc = cyc;
                    if (rsp_q.size() != 0) begin
                        re = rsp_q.pop_front();
                        chk("rsp_data", bus.rsp_outputs_0, re.data);
                    end
                end
            end
        end
    end

    // Issue one command; returns one time unit after the accepting edge.
    task automatic send(input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int fk, input logic [31:0] fv,
                        input bit has_rsp, input logic [31:0] rd, input int lat,
                        input bit b2b);
        bit accepted = 1'b0;
        if (fk != 0) flg_q.push_back('{kind: fk, val: fv});
        if (has_rsp) rsp_q.push_back('{data: rd, lat: lat});
        bus.cmd_valid       = 1'b1;
        bus.cmd_function_id = {f7, f3};
        bus.cmd_inputs_0    = a;
        bus.cmd_inputs_1    = b;
        for (int t = 0; t < 64 && !accepted; t++) begin
            if (bus.cmd_ready === 1'b1) accepted = 1'b1;
            else @(negedge clk);
        end
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no cmd_ready in 64 cycles, required accept");
        end else begin
            acc_cyc = cyc;
            if (b2b) chk("turnaround", 32'(acc_cyc), 32'(hs_cyc + 1));
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((rsp_q.size() != 0 || flg_q.size() != 0 || bus.rsp_valid === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t >= 100), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid       = 1'b0;
        bus.cmd_function_id = 10'd0;
        bus.cmd_inputs_0    = 32'd0;
        bus.cmd_inputs_1    = 32'd0;
        bus.rsp_ready       = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_data", bus.rsp_outputs_0, 32'd0);
        chk("rst_value_out", value_out, 32'd0);
        chk("rst_flags", {29'd0, flag_write_offset, flag_add_acc, flag_clear_acc}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // write offset then read it back
        send(7'd0, OP_WR_OFF, 32'd128, 32'd0, K_WR, 32'd128, 1'b1, 32'd128, 2, 1'b0);
        wait_done();
        send(7'd0, OP_RD_OFF, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd128, 2, 1'b0);
        wait_done();

        // unsigned-looking MAC with offset 128: 132+131+130+129 = 522
        send(7'd0, OP_CLR_ACC, 32'd0, 32'd0, K_CLR, 32'd0, 1'b1, 32'd0, 2, 1'b0);
        wait_done();
        send(7'd0, OP_MAC, 32'h0102_0304, 32'h0101_0101, K_ADD, 32'd522, 1'b1, 32'd522, MAC_LAT, 1'b0);
        wait_done();
        // negative weights: S = -522, acc back to 0
        send(7'd0, OP_MAC, 32'h0102_0304, 32'hFFFF_FFFF, K_ADD, 32'hFFFF_FDF6, 1'b1, 32'd0, MAC_LAT, 1'b0);
        wait_done();
        send(7'd0, OP_RD_ACC, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0, 2, 1'b0);
        wait_done();

        // offset 0, all lanes -128 * -128: S = 4 * 16384 = 65536
        send(7'd0, OP_WR_OFF, 32'd0, 32'd0, K_WR, 32'd0, 1'b1, 32'd0, 2, 1'b0);
        wait_done();
        send(7'd0, OP_CLR_ACC, 32'd0, 32'd0, K_CLR, 32'd0, 1'b1, 32'd0, 2, 1'b0);
        wait_done();
        send(7'd0, OP_MAC, 32'h8080_8080, 32'h8080_8080, K_ADD, 32'd65536, 1'b1, 32'd65536, MAC_LAT, 1'b0);
        wait_done();

        // backpressure: response held for 5 cycles
        bus.rsp_ready = 1'b0;
        send(7'd0, OP_RD_ACC, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd65536, 2, 1'b0);
        for (int t = 0; t < 10 && bus.rsp_valid !== 1'b1; t++) @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_done();

        // reset mid-MAC: no flag, no response, registers untouched
        send(7'd0, OP_MAC, 32'h0101_0101, 32'h0101_0101, 0, 32'd0, 1'b0, 32'd0, 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_acc", acc_m, 32'd65536);
        chk("abort_off", off_m, 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        send(7'd0, OP_RD_ACC, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd65536, 2, 1'b0);
        wait_done();

        // undefined funct3 with funct7 set, then back-to-back commands
        send(7'h7F, 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 0, 32'd0, 1'b1, 32'd0, 2, 1'b0);
        send(7'd0, OP_RD_OFF, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0, 2, 1'b1);
        send(7'h7F, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 1'b1, 32'd0, 2, 1'b1);
        send(7'h7F, OP_RD_ACC, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd65536, 2, 1'b1);
        wait_done();

        repeat (2) @(negedge clk);
        chk("queues_empty", 32'(rsp_q.size() + flg_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_ctrl.md
Name: cfu_ctrl

Overview:
- CFU-bus responder: accepts CPU custom-instruction commands and drives the offset/accumulator register block through one-cycle flag pulses and a shared 32-bit value bus.
- Executes a 4-lane int8 MAC using the current offset, then returns a 32-bit response to the CPU.
- Sits between the CPU CFU port and the register block; it owns all handshakes and sequencing.

Parameters:
- LANES, 4, number of packed int8 lanes per MAC operand word.
- LANE_W, 8, lane width in bits; LANES*LANE_W must equal 32.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_function_id  in  10  funct7 in [9:3], funct3 in [2:0]; only funct3 is decoded, funct7 is ignored.
- cmd_inputs_0  in  32  rs1 operand.
- cmd_inputs_1  in  32  rs2 operand.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts response.
- rsp_outputs_0  out  32  response data.
- flag_write_offset  out  1  one-cycle pulse; register block loads value_out into offset.
- flag_add_acc  out  1  one-cycle pulse; register block adds value_out to acc.
- flag_clear_acc  out  1  one-cycle pulse; register block clears acc.
- value_out  out  32  signed operand for the register block.
- offset_in  in  32  current offset from the register block.
- acc_in  in  32  current accumulator from the register block.

Behaviour:
- Reset: state IDLE; cmd_ready=0 during reset and 1 in the cycle after; rsp_valid=0; all flags 0; value_out=0; rsp_outputs_0=0.
- Reset mid-operation aborts the command: no flag is emitted after reset asserts and no response is produced.
- Opcodes (funct3):
  - 0 WR_OFF: pulse flag_write_offset, value_out=in0; response = new offset.
  - 1 CLR_ACC: pulse flag_clear_acc; response = 0.
  - 2 MAC: pulse flag_add_acc, value_out=S; response = new acc.
  - 3 RD_ACC: no flag; response = acc_in.
  - 4 RD_OFF: no flag; response = offset_in.
  - 5-7: no flag; response = 0.
- MAC arithmetic: S = sum over i<LANES of (sext(in0 lane i) + offset_in) * sext(in1 lane i).
  - Lane i occupies bits [8i+7:8i].
  - All arithmetic is 32-bit signed, wrapping mod 2^32, with no saturation.
- States: IDLE, PROD, EXEC, RSP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch operands and funct3. Go to PROD if MAC and the product stage is compiled in, else EXEC.
  - PROD: register the LANES products; go to EXEC.
  - EXEC: assert exactly one flag (or none) plus value_out for one cycle; go to RSP.
  - RSP: rsp_valid=1; rsp_outputs_0 is the mux of acc_in/offset_in/0 per opcode. Hold until rsp_valid&&rsp_ready, then go to IDLE.
- RSP data is stable while rsp_valid is held, because no flags fire while in RSP.
- Latency (accept edge to rsp_valid): 2 cycles for non-MAC ops; 3 for MAC with the product stage, 2 without.
- cmd_ready=0 in PROD, EXEC and RSP, so commands are single-outstanding and backpressure is held.
- Response-to-command turnaround is 1 cycle: the earliest next accept is the cycle after the response handshake.
- At most one flag is high in any cycle; flags are never high outside EXEC.

Optional Feature:
- CFU_CTRL_PROD_STAGE_EN defined: the PROD state exists and products are registered; MAC latency is 3.
- Undefined: PROD is removed and products plus sum are combinational from latched operands in EXEC; MAC latency is 2.
- Results are identical either way.

Decomposition:
- Package cfu_ctrl_pkg holds:
  - the opcode constants OP_WR_OFF=0, OP_CLR_ACC=1, OP_MAC=2, OP_RD_ACC=3, OP_RD_OFF=4;
  - the state enum;
  - LANES and LANE_W defaults.
- Sub-module cfu_mac_lanes: combinational per-lane offset-add, multiply and sum tree, instantiated once.

Test Plan:
- Write offset: in0=128 → flag_write_offset pulses once, value_out=128; after 2 cycles response=128; RD_OFF then returns 128.
- MAC: offset=128, acc cleared, in0=0x01020304, in1=0x01010101 → flag_add_acc pulses with value_out=522; rsp=522 (0x20A).
- Signed MAC: repeat with in1=0xFFFFFFFF → value_out=-522, rsp=0. Repeat with offset=0, in0=0x80808080, in1=0x80808080 → S=65536.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and data stay stable, cmd_ready=0, and no flag pulses.
- Reset in EXEC/PROD during a MAC → no flag after reset, rsp_valid=0, acc_in unchanged; the next command completes normally.
- funct3=6 with funct7=0x7F → no flags, rsp=0; back-to-back commands are accepted the cycle after each response handshake.
